alu_control_unit: RTL and testbench

Control stage directly upstream of the ALU. Latches the two 8-bit operands from a shared data bus and converts a 4-bit opcode into the ALU's 16-bit one-hot `selector`. A fixed-length state machine holds each operation on the ALU for a programmable number of cycles and then signals completion. Illegal opcodes are rejected with an error pulse instead of driving the ALU.

---
 rtl/alu_control_unit.sv | 150 +++++++++++++++
 tb/tb_alu_control_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/alu_control_unit.sv
// alu_control_unit: control stage in front of the ALU.
// It latches operands A and B from a shared bus and decodes a 4-bit opcode
// into a one-hot selector. The selector is held for EXEC_CYCLES cycles and
// then done pulses. An illegal opcode pulses err and never drives the selector.
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   data_in             - operand bus
//   load_a, load_b      - capture data_in into a / b (honoured in IDLE only)
//   opcode, start       - operation request (honoured in IDLE only)
//   a, b                - registered operands to the ALU
//   selector            - registered one-hot operation select, zero when idle
//   busy, done, err     - registered status; done and err are 1-cycle pulses
//   op_count            - completed legal operations, wraps modulo 256
module alu_control_unit #(
  parameter int unsigned EXEC_CYCLES = 2,
  parameter int unsigned NUM_OPS     = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic        load_a,
  input  logic        load_b,
  input  logic [3:0]  opcode,
  input  logic        start,
  output logic [7:0]  a,
  output logic [7:0]  b,
  output logic [15:0] selector,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  op_count
);

  localparam int unsigned DW   = 8;
  localparam int unsigned OPW  = 4;
  localparam int unsigned SELW = 16;
  localparam int unsigned CNTW = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_EXECUTE,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [DW-1:0]   op_count_q, op_count_d;
  logic            op_legal_c;

  // One extra bit so NUM_OPS = 16 compares correctly against a 4-bit opcode.
  assign op_legal_c = ((OPW+1)'(op_q) < (OPW+1)'(NUM_OPS));

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      cnt_q      <= '0;
      sel_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      op_count_q <= op_count_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    op_count_d = op_count_q;

    case (state_q)
      S_IDLE: begin
        if (load_a) a_d = data_in;
        if (load_b) b_d = data_in;
        if (start) begin
          op_d    = opcode;
          busy_d  = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op_legal_c) begin
          sel_d   = SELW'(1) << op_q;
          cnt_d   = CNTW'(EXEC_CYCLES - 1);
          state_d = S_EXECUTE;
        end else begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_EXECUTE: begin
        // The counter reaches zero on the last cycle the selector is held.
        if (cnt_q == '0) begin
          sel_d      = '0;
          done_d     = 1'b1;
          op_count_d = op_count_q + DW'(1);
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      S_DONE: begin
        done_d  = 1'b0;
        err_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign a        = a_q;
  assign b        = b_q;
  assign selector = sel_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign op_count = op_count_q;

endmodule

// File: tb/tb_alu_control_unit.sv
// Bench for alu_control_unit: a per-cycle compare against a timeline model,
// plus directed scenarios with literal expectations.
module tb_alu_control_unit;

  localparam int unsigned EXEC = 2;
  localparam int unsigned NOPS = 9;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  data_in;
  logic        load_a, load_b, start;
  logic [3:0]  opcode;
  logic [7:0]  a, b, op_count;
  logic [15:0] selector;
  logic        busy, done, err;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  alu_control_unit #(.EXEC_CYCLES(EXEC), .NUM_OPS(NOPS)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .load_a(load_a), .load_b(load_b),
    .opcode(opcode), .start(start), .a(a), .b(b), .selector(selector),
    .busy(busy), .done(done), .err(err), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Timeline model: an accepted operation is tracked by how many edges have
  // passed since the start edge (m_d = 0 right after it).
  logic [7:0] m_a, m_b, m_cnt;
  bit         m_active;
  int         m_d, m_op;

  always @(posedge clk) begin
    if (reset) begin
      m_a = 0; m_b = 0; m_cnt = 0; m_active = 0; m_d = 0; m_op = 0;
    end else if (!m_active) begin
      if (load_a) m_a = data_in;
      if (load_b) m_b = data_in;
      if (start) begin
        m_active = 1; m_op = int'(opcode); m_d = 0;
      end
    end else begin
      m_d++;
      if (m_op < int'(NOPS)) begin
        if (m_d == int'(EXEC) + 1) m_cnt = m_cnt + 8'd1;
        if (m_d == int'(EXEC) + 2) m_active = 0;
      end else if (m_d == 2) begin
        m_active = 0;
      end
    end
  end

  // Compare every cycle, shortly after the active edge.
  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      logic        legal;
      logic [15:0] e_sel;
      legal = (m_op < int'(NOPS));
      e_sel = 16'h0;
      if (m_active && legal && m_d >= 1 && m_d <= int'(EXEC)) e_sel = 16'h1 << m_op;
      chk("a", 32'(a), 32'(m_a));
      chk("b", 32'(b), 32'(m_b));
      chk("selector", 32'(selector), 32'(e_sel));
      chk("busy", 32'(busy), 32'(m_active));
      chk("done", 32'(done), 32'(m_active && legal && m_d == int'(EXEC) + 1));
      chk("err", 32'(err), 32'(m_active && !legal && m_d == 1));
      chk("op_count", 32'(op_count), 32'(m_cnt));
    end
  end

  // Issue one operation at a negedge; returns between edges T+2+EXEC and T+3+EXEC.
  task automatic run_op(input logic [3:0] op, input logic [15:0] exp_sel, input bit legal);
    start = 1'b1; opcode = op;
    @(negedge clk);
    start = 1'b0; load_a = 1'b0; load_b = 1'b0;
    chk("op_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("op_sel", 32'(selector), 32'(exp_sel));
    chk("op_err", 32'(err), 32'(!legal));
    repeat (EXEC) @(negedge clk);
    chk("op_done", 32'(done), 32'(legal));
    chk("op_sel_clr", 32'(selector), 32'd0);
    @(negedge clk);
    chk("op_idle", 32'(busy), 32'd0);
  endtask

  logic [15:0] sel_tab [0:8];

  initial begin
    sel_tab[0] = 16'h0001; sel_tab[1] = 16'h0002; sel_tab[2] = 16'h0004;
    sel_tab[3] = 16'h0008; sel_tab[4] = 16'h0010; sel_tab[5] = 16'h0020;
    sel_tab[6] = 16'h0040; sel_tab[7] = 16'h0080; sel_tab[8] = 16'h0100;
    reset = 1'b1; data_in = '0; load_a = 0; load_b = 0; start = 0; opcode = '0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_sel", 32'(selector), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(op_count), 32'd0);
    reset = 1'b0;

    // Operand load
    data_in = 8'h59; load_a = 1'b1;
    @(negedge clk);
    load_a = 1'b0;
    chk("load_a", 32'(a), 32'h59);
    data_in = 8'h72; load_b = 1'b1;
    @(negedge clk);
    load_b = 1'b0;
    chk("load_b", 32'(b), 32'h72);
    chk("load_a_hold", 32'(a), 32'h59);

    // Sweep of legal opcodes
    for (int i = 0; i < 9; i++) run_op(4'(i), sel_tab[i], 1'b1);
    chk("sweep_count", 32'(op_count), 32'd9);

    // Illegal opcode
    run_op(4'd12, 16'h0000, 1'b0);
    chk("illegal_count", 32'(op_count), 32'd9);

    // Load together with start still takes effect
    data_in = 8'h3C; load_b = 1'b1;
    run_op(4'd1, 16'h0002, 1'b1);
    chk("load_with_start", 32'(b), 32'h3C);

    // Ignore while busy
    start = 1'b1; opcode = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; opcode = 4'd5; load_a = 1'b1; data_in = 8'hFF;
    @(negedge clk);
    start = 1'b0; load_a = 1'b0;
    chk("busy_sel_hold", 32'(selector), 32'h0008);
    chk("busy_a_hold", 32'(a), 32'h59);
    @(negedge clk);
    chk("busy_done", 32'(done), 32'd1);
    repeat (4) @(negedge clk);
    chk("busy_no_second", 32'(busy), 32'd0);
    chk("busy_count", 32'(op_count), 32'd11);

    // Reset mid-EXECUTE
    start = 1'b1; opcode = 4'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("mid_sel", 32'(selector), 32'h0010);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_sel", 32'(selector), 32'd0);
    chk("mid_rst_ab", 32'({a, b}), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cnt", 32'(op_count), 32'd0);
    run_op(4'd0, 16'h0001, 1'b1);
    chk("mid_after_cnt", 32'(op_count), 32'd1);

    // Counter wrap
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 256; k++) begin
      run_op(4'(k % 9), 16'h1 << (k % 9), 1'b1);
      if (k == 255) chk("wrap_255", 32'(op_count), 32'd255);
      if (k == 256) chk("wrap_0", 32'(op_count), 32'd0);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
